// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard-controller FSM encoding and frame-copy kinds.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } hz_state_t;

  localparam logic COPY_KIND_FLUSH = 1'b0;
  localparam logic COPY_KIND_COPY  = 1'b1;

  function automatic logic src_matches(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator between the ID-stage sources and the EX-stage load destination.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_to_reg,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_wadr,
  output logic       load_use
);

  // $0 is hardwired to zero, so a load into it never creates a dependency.
  always_comb begin
    load_use = ex_mem_to_reg && ex_reg_write && (ex_wadr != 5'd0) &&
               (src_matches(id_uses_rs, id_rs, ex_wadr) ||
                src_matches(id_uses_rt, id_rt, ex_wadr));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and the
// multi-cycle frame-copy handshake that freezes the pipeline while it runs.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned COPY_TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        EX_MemToReg,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_WAdr,
  input  logic        EX_BranchTaken,
  input  logic        MEM_FrameFlush,
  input  logic        MEM_CopyToRAM,
  input  logic        Copy_Done,
  input  logic        Stall_Clr,
  output logic        PC_Stall,
  output logic        IFID_Stall,
  output logic        IDEX_Stall,
  output logic        EXMEM_Stall,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        MEMWB_Bubble,
  output logic        Copy_Start,
  output logic        Copy_Kind,
  output logic        Busy,
  output logic        Copy_Err,
  output logic [31:0] Stall_Cycles
);

  localparam int unsigned TW = (COPY_TIMEOUT > 1) ? $clog2(COPY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(COPY_TIMEOUT - 1);

  hz_state_t     state;
  logic [TW-1:0] timeout_cnt;
  logic          copy_kind_q;
  logic          copy_err_q;
  logic [31:0]   stall_cnt;
  logic          load_use;

  hazard_detect u_hazard_detect (
    .id_rs        (ID_Rs),
    .id_rt        (ID_Rt),
    .id_uses_rs   (ID_UsesRs),
    .id_uses_rt   (ID_UsesRt),
    .ex_mem_to_reg(EX_MemToReg),
    .ex_reg_write (EX_RegWrite),
    .ex_wadr      (EX_WAdr),
    .load_use     (load_use)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= ST_RUN;
      timeout_cnt <= '0;
      copy_kind_q <= COPY_KIND_FLUSH;
      copy_err_q  <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (Stall_Clr)
        stall_cnt <= '0;
      else if (PC_Stall)
        stall_cnt <= stall_cnt + 32'd1;

      unique case (state)
        ST_RUN: begin
          if (MEM_FrameFlush || MEM_CopyToRAM) begin
            state       <= ST_START;
            copy_kind_q <= MEM_FrameFlush ? COPY_KIND_FLUSH : COPY_KIND_COPY;
          end
        end
        ST_START: begin
          state       <= ST_WAIT;
          timeout_cnt <= '0;
        end
        ST_WAIT: begin
          if (Copy_Done) begin
            state <= ST_RELEASE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            copy_err_q <= 1'b1;
            state      <= ST_RELEASE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        ST_RELEASE: state <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    PC_Stall     = 1'b0;
    IFID_Stall   = 1'b0;
    IDEX_Stall   = 1'b0;
    EXMEM_Stall  = 1'b0;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    MEMWB_Bubble = 1'b0;
    Copy_Start   = 1'b0;
    Busy         = 1'b0;
    unique case (state)
      ST_START, ST_WAIT: begin
        PC_Stall     = 1'b1;
        IFID_Stall   = 1'b1;
        IDEX_Stall   = 1'b1;
        EXMEM_Stall  = 1'b1;
        MEMWB_Bubble = 1'b1;
        Busy         = 1'b1;
        // Reset aborts the operation before the engine ever sees a start.
        Copy_Start   = (state == ST_START) && !Reset;
      end
      ST_RUN, ST_RELEASE: begin
        if (EX_BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (load_use) begin
          PC_Stall   = 1'b1;
          IFID_Stall = 1'b1;
          IDEX_Flush = 1'b1;
        end
      end
    endcase
  end

  assign Copy_Kind    = copy_kind_q;
  assign Copy_Err     = copy_err_q;
  assign Stall_Cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default-timeout and short-timeout instances.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_WAdr;
  logic        ID_UsesRs, ID_UsesRt, EX_MemToReg, EX_RegWrite, EX_BranchTaken;
  logic        MEM_FrameFlush, MEM_CopyToRAM, Copy_Done, Stall_Clr;

  logic        pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, bub, cstart, ckind, busy, cerr;
  logic [31:0] cycles;
  logic        pc_s8, ifid_s8, idex_s8, exmem_s8, ifid_f8, idex_f8, bub8, cstart8, ckind8, busy8, cerr8;
  logic [31:0] cycles8;

  logic [9:0] ctl, ctl8;
  assign ctl  = {pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, bub, cstart, busy, cerr};
  assign ctl8 = {pc_s8, ifid_s8, idex_s8, exmem_s8, ifid_f8, idex_f8, bub8, cstart8, busy8, cerr8};

  // Bit order: PC_Stall IFID_Stall IDEX_Stall EXMEM_Stall IFID_Flush IDEX_Flush MEMWB_Bubble Copy_Start Busy Copy_Err
  localparam logic [9:0] C_IDLE   = 10'b0000000000;
  localparam logic [9:0] C_LU     = 10'b1100010000;
  localparam logic [9:0] C_BR     = 10'b0000110000;
  localparam logic [9:0] C_START  = 10'b1111001110;
  localparam logic [9:0] C_WAIT   = 10'b1111001010;
  localparam logic [9:0] C_ERR    = 10'b0000000001;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_start = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (cstart) n_start++;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_MemToReg(EX_MemToReg), .EX_RegWrite(EX_RegWrite), .EX_WAdr(EX_WAdr),
    .EX_BranchTaken(EX_BranchTaken), .MEM_FrameFlush(MEM_FrameFlush),
    .MEM_CopyToRAM(MEM_CopyToRAM), .Copy_Done(Copy_Done), .Stall_Clr(Stall_Clr),
    .PC_Stall(pc_s), .IFID_Stall(ifid_s), .IDEX_Stall(idex_s), .EXMEM_Stall(exmem_s),
    .IFID_Flush(ifid_f), .IDEX_Flush(idex_f), .MEMWB_Bubble(bub), .Copy_Start(cstart),
    .Copy_Kind(ckind), .Busy(busy), .Copy_Err(cerr), .Stall_Cycles(cycles)
  );

  pipeline_hazard_ctrl #(.COPY_TIMEOUT(8)) dut_t8 (
    .CLK(CLK), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .EX_MemToReg(EX_MemToReg), .EX_RegWrite(EX_RegWrite), .EX_WAdr(EX_WAdr),
    .EX_BranchTaken(EX_BranchTaken), .MEM_FrameFlush(MEM_FrameFlush),
    .MEM_CopyToRAM(MEM_CopyToRAM), .Copy_Done(Copy_Done), .Stall_Clr(Stall_Clr),
    .PC_Stall(pc_s8), .IFID_Stall(ifid_s8), .IDEX_Stall(idex_s8), .EXMEM_Stall(exmem_s8),
    .IFID_Flush(ifid_f8), .IDEX_Flush(idex_f8), .MEMWB_Bubble(bub8), .Copy_Start(cstart8),
    .Copy_Kind(ckind8), .Busy(busy8), .Copy_Err(cerr8), .Stall_Cycles(cycles8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs = '0; ID_Rt = '0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
    EX_MemToReg = 1'b0; EX_RegWrite = 1'b0; EX_WAdr = '0; EX_BranchTaken = 1'b0;
    MEM_FrameFlush = 1'b0; MEM_CopyToRAM = 1'b0; Copy_Done = 1'b0; Stall_Clr = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] wadr);
    EX_MemToReg = 1'b1; EX_RegWrite = 1'b1; EX_WAdr = wadr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    Reset = 1'b1;
    step();
    step();
    chk("reset_ctl", 32'(ctl), 32'(C_IDLE));
    chk("reset_cycles", cycles, 32'd0);
    chk("reset_kind", 32'(ckind), 32'd0);
    Reset = 1'b0;
    #1;
    chk("run_idle_ctl", 32'(ctl), 32'(C_IDLE));

    // Load-use on Rs: one bubble, counter 0 -> 1
    set_load(5'd5); ID_Rs = 5'd5; ID_UsesRs = 1'b1; ID_Rt = 5'd9; ID_UsesRt = 1'b1;
    #1 chk("lu_rs_ctl", 32'(ctl), 32'(C_LU));
    step();
    clear_inputs();
    #1 chk("lu_rs_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("lu_rs_cycles", cycles, 32'd1);

    // Rt match, then qualifiers removed one at a time
    set_load(5'd7); ID_Rs = 5'd3; ID_UsesRs = 1'b1; ID_Rt = 5'd7; ID_UsesRt = 1'b0;
    #1 chk("rt_unused_ctl", 32'(ctl), 32'(C_IDLE));
    ID_UsesRt = 1'b1; EX_RegWrite = 1'b0;
    #1 chk("no_regwrite_ctl", 32'(ctl), 32'(C_IDLE));
    EX_RegWrite = 1'b1; EX_MemToReg = 1'b0;
    #1 chk("not_load_ctl", 32'(ctl), 32'(C_IDLE));
    EX_MemToReg = 1'b1;
    #1 chk("lu_rt_ctl", 32'(ctl), 32'(C_LU));
    step();
    clear_inputs();
    #1 chk("lu_rt_cycles", cycles, 32'd2);

    // Load into $0 never stalls; branch overrides load-use
    set_load(5'd0); ID_Rs = 5'd0; ID_UsesRs = 1'b1;
    #1 chk("lu_r0_ctl", 32'(ctl), 32'(C_IDLE));
    set_load(5'd5); ID_Rs = 5'd5; EX_BranchTaken = 1'b1;
    #1 chk("br_over_lu_ctl", 32'(ctl), 32'(C_BR));
    step();
    clear_inputs();
    EX_BranchTaken = 1'b1;
    #1 chk("br_only_ctl", 32'(ctl), 32'(C_BR));
    chk("br_cycles", cycles, 32'd2);

    // Stray Copy_Done in RUN is ignored
    clear_inputs();
    Copy_Done = 1'b1;
    step();
    Copy_Done = 1'b0;
    #1 chk("stray_done_ctl", 32'(ctl), 32'(C_IDLE));

    // FrameFlush with Copy_Done on the 10th WAIT cycle; request held through RELEASE
    n_start = 0;
    MEM_FrameFlush = 1'b1;
    #1 chk("ff_run_ctl", 32'(ctl), 32'(C_IDLE));
    step();
    set_load(5'd5); ID_Rs = 5'd5; ID_UsesRs = 1'b1;
    #1 chk("ff_start_ctl", 32'(ctl), 32'(C_START));
    chk("ff_kind", 32'(ckind), 32'd0);
    step();
    for (int i = 1; i <= 10; i++) begin
      EX_BranchTaken = (i == 3);
      Copy_Done = (i == 10);
      #1 chk("ff_wait_ctl", 32'(ctl), 32'(C_WAIT));
      step();
    end
    Copy_Done = 1'b0;
    EX_BranchTaken = 1'b0;
    #1 chk("ff_release_lu_ctl", 32'(ctl), 32'(C_LU));
    chk("ff_stall_cycles", cycles, 32'd13);
    step();
    clear_inputs();
    #1 chk("ff_back_run_ctl", 32'(ctl), 32'(C_IDLE));
    chk("ff_release_cycles", cycles, 32'd14);
    step();
    chk("ff_still_run_ctl", 32'(ctl), 32'(C_IDLE));
    chk("ff_one_start", n_start, 32'd1);

    // Timeout on the COPY_TIMEOUT=8 instance; both requests -> FrameFlush kind
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    MEM_FrameFlush = 1'b1; MEM_CopyToRAM = 1'b1;
    step();
    clear_inputs();
    #1 chk("to_start_ctl", 32'(ctl8), 32'(C_START));
    chk("to_both_kind", 32'(ckind8), 32'd0);
    step();
    for (int i = 1; i <= 8; i++) begin
      #1 chk("to_wait_ctl", 32'(ctl8), 32'(C_WAIT));
      step();
    end
    chk("to_release_ctl", 32'(ctl8), 32'(C_ERR));
    step();
    chk("to_run_err_ctl", 32'(ctl8), 32'(C_ERR));

    // CopyToRAM alone -> kind 1; Copy_Err stays sticky through a good copy
    MEM_CopyToRAM = 1'b1;
    step();
    clear_inputs();
    #1 chk("ctr_start_ctl", 32'(ctl8), 32'(C_START | C_ERR));
    chk("ctr_kind", 32'(ckind8), 32'd1);
    step();
    Copy_Done = 1'b1;
    #1 chk("ctr_wait_ctl", 32'(ctl8), 32'(C_WAIT | C_ERR));
    step();
    Copy_Done = 1'b0;
    #1 chk("ctr_release_ctl", 32'(ctl8), 32'(C_ERR));

    // Reset during WAIT aborts the operation
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    MEM_CopyToRAM = 1'b1;
    step();
    clear_inputs();
    #1 chk("rw_kind", 32'(ckind), 32'd1);
    step();
    step();
    Reset = 1'b1;
    #1 chk("rw_wait_ctl", 32'(ctl), 32'(C_WAIT));
    step();
    Reset = 1'b0;
    #1 chk("rw_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rw_after_cycles", cycles, 32'd0);
    chk("rw_after_kind", 32'(ckind), 32'd0);
    chk("rw_after_err8", 32'(cerr8), 32'd0);

    // Reset during START suppresses the start pulse
    n_start = 0;
    MEM_FrameFlush = 1'b1;
    step();
    clear_inputs();
    Reset = 1'b1;
    #1 chk("rs_start_pulse", 32'(cstart), 32'd0);
    step();
    Reset = 1'b0;
    #1 chk("rs_after_ctl", 32'(ctl), 32'(C_IDLE));
    chk("rs_no_start", n_start, 32'd0);

    // Stall counter wrap and clear priority
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    #1 chk("wrap_preload", cycles, 32'hFFFF_FFFE);
    set_load(5'd4); ID_Rt = 5'd4; ID_UsesRt = 1'b1;
    step();
    chk("wrap_max", cycles, 32'hFFFF_FFFF);
    step();
    chk("wrap_zero", cycles, 32'd0);
    step();
    chk("wrap_one", cycles, 32'd1);
    Stall_Clr = 1'b1;
    #1 chk("clr_lu_ctl", 32'(ctl), 32'(C_LU));
    step();
    chk("clr_wins", cycles, 32'd0);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: COPY_TIMEOUT, default 4096, maximum cycles to wait for Copy_Done before aborting.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ID_Rs, ID_Rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 ID_UsesRs, ID_UsesRt  in  1 each  ID instruction actually reads Rs / Rt.
REQ-006 EX_MemToReg, EX_RegWrite  in  1 each  EX instruction is a load / writes a register.
REQ-007 EX_WAdr  in  5  destination register of the EX instruction.
REQ-008 EX_BranchTaken  in  1  branch or jump in EX resolved taken.
REQ-009 MEM_FrameFlush, MEM_CopyToRAM  in  1 each  MEM instruction requests a multi-cycle screen operation.
REQ-010 Copy_Done  in  1  one-cycle acknowledge from the frame-copy engine.
REQ-011 Stall_Clr  in  1  clears Stall_Cycles.
REQ-012 PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall  out  1 each  hold the corresponding register.
REQ-013 IFID_Flush, IDEX_Flush  out  1 each  load a bubble (all-zero control) into the register.
REQ-014 MEMWB_Bubble  out  1  forces MEM_WB control inputs (RegWrite, MemToReg, JAL, CopyToRAM, FrameFlush) to 0.
REQ-015 Copy_Start  out  1  one-cycle start pulse to the frame-copy engine.
REQ-016 Copy_Kind  out  1  0 = FrameFlush, 1 = CopyToRAM; valid while Busy.
REQ-017 Busy, Copy_Err  out  1 each  screen operation in progress / sticky timeout flag.
REQ-018 Stall_Cycles  out  32  count of cycles with PC_Stall high.

Function
REQ-019 Load-use hazard SHALL be EX_MemToReg & EX_RegWrite & EX_WAdr!=0 & ((ID_UsesRs & ID_Rs==EX_WAdr) | (ID_UsesRt & ID_Rt==EX_WAdr)).
REQ-020 In RUN, load-use SHALL assert PC_Stall, IFID_Stall, IDEX_Flush for exactly that cycle (one bubble).
REQ-021 In RUN, EX_BranchTaken SHALL assert IFID_Flush and IDEX_Flush and SHALL override load-use (no stall that cycle).
REQ-022 FSM states: RUN, START, WAIT, RELEASE; all outputs combinational from state and inputs.
REQ-023 RUN -> START when MEM_FrameFlush | MEM_CopyToRAM; Copy_Kind latched = ~MEM_FrameFlush (FrameFlush wins if both).
REQ-024 START: Copy_Start=1 for one cycle; -> WAIT.
REQ-025 START and WAIT: PC/IFID/IDEX/EXMEM stalls all 1, MEMWB_Bubble=1, Busy=1, both flushes 0, load-use ignored.
REQ-026 WAIT -> RELEASE on Copy_Done; Copy_Done in any other state is ignored.
REQ-027 WAIT: timeout counter SHALL count from 0; at COPY_TIMEOUT-1 without Copy_Done, set Copy_Err and -> RELEASE.
REQ-028 RELEASE: all stalls 0, MEMWB_Bubble 0, Busy 0; MEM request inputs SHALL NOT retrigger; hazard/branch rules of REQ-020/021 apply; -> RUN.
REQ-029 Stall_Cycles SHALL increment by 1 per cycle with PC_Stall=1, wrapping 0xFFFFFFFF -> 0; Stall_Clr wins over increment.
REQ-030 Copy_Err SHALL stay set until Reset.

Reset
REQ-031 Reset SHALL force state RUN, timeout counter 0, Copy_Kind 0, Copy_Err 0, Stall_Cycles 0; all outputs then evaluate to 0 absent hazards.
REQ-032 Reset during START/WAIT SHALL abort the operation with no Copy_Start emitted in the reset cycle.

Structure
REQ-033 FSM state encoding and COPY_KIND constants SHALL live in shared package cpu_pkg.
REQ-034 Load-use comparator SHALL be a sub-module hazard_detect (purely combinational); FSM, counters in top.

Verification
REQ-035 EX lw $5, ID add using Rs=5 -> one cycle PC_Stall=IFID_Stall=IDEX_Flush=1, Stall_Cycles 0->1.
REQ-036 EX lw $0, ID uses $0 -> no stall; EX_BranchTaken with load-use -> flushes only, PC_Stall=0.
REQ-037 MEM_FrameFlush=1, Copy_Done after 10 WAIT cycles -> Copy_Start pulse once, Copy_Kind=0, stalls 11 cycles, RELEASE once, no second Copy_Start.
REQ-038 MEM_CopyToRAM and MEM_FrameFlush both 1 -> Copy_Kind=0; COPY_TIMEOUT=8, no Copy_Done -> Copy_Err=1 after 8 WAIT cycles, RELEASE.
REQ-039 Reset asserted in WAIT -> next cycle RUN, Busy=0, all outputs 0, Stall_Cycles=0.
REQ-040 Preload Stall_Cycles near 0xFFFFFFFF via long stall -> wraps to 0; Stall_Clr with PC_Stall same cycle -> 0.
